// File: rtl/uart_rx_core.sv
// UART receiver with oversampled start/data/parity/stop decoding feeding a
// first-word-fall-through receive FIFO with sticky line/overrun error flags.
module uart_rx_core #(
    parameter int DATABUS    = 8,
    parameter int DEPTH      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               baud_tick,
    input  logic               rxd,
    input  logic               parity_en,
    input  logic               parity_odd,
    input  logic               pop,
    input  logic               err_clr,
    output logic [DATABUS-1:0] pop_data_out,
    output logic               empty,
    output logic               full,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overrun_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATABUS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATABUS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rxs;

    logic [2:0]         r_state;
    logic               r_armed;
    logic [TW-1:0]      r_tick_cnt;
    logic [BW-1:0]      r_bit_cnt;
    logic [DATABUS-1:0] r_shift;
    logic               r_push;
    logic [DATABUS-1:0] r_push_data;
    logic               r_frame_err;
    logic               r_parity_err;
    logic               r_overrun_err;

    logic [DATABUS-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [DATABUS-1:0] r_dout;

    logic               w_empty;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_overrun_set;
    logic [AW:0]        w_wr_next;
    logic [AW:0]        w_rd_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // The whole FSM advances only on baud ticks; r_push is a one-clk pulse
    // that commits the assembled word to the FIFO on the following clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (err_clr) begin
                r_frame_err  <= 1'b0;
                r_parity_err <= 1'b0;
            end
            if (baud_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_armed) begin
                            if (w_rxs) r_armed <= 1'b1;
                        end else if (!w_rxs) begin
                            r_state    <= S_START;
                            r_tick_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tick_cnt == TICK_HALF) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_state    <= w_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= DATABUS'({w_rxs, r_shift} >> 1);
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= parity_en ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_STOP;
                            if (w_rxs != ((^r_shift) ^ parity_odd)) r_parity_err <= 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_IDLE;
                            if (w_rxs) begin
                                r_push      <= 1'b1;
                                r_push_data <= r_shift;
                                r_armed     <= 1'b1;
                            end else begin
                                // Break or bad stop: wait for the line to go idle again.
                                r_frame_err <= 1'b1;
                                r_armed     <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_armed    <= 1'b0;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop      = pop & ~w_empty;
    assign w_do_push     = r_push & (~w_full | w_do_pop);
    assign w_overrun_set = r_push & w_full & ~pop;
    assign w_wr_next     = r_wr_ptr + {{AW{1'b0}}, w_do_push};
    assign w_rd_next     = r_rd_ptr + {{AW{1'b0}}, w_do_pop};

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_overrun_err <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            if (err_clr) r_overrun_err <= 1'b0;
            if (w_overrun_set) r_overrun_err <= 1'b1;
        end
    end

    // Registered head-of-FIFO: the new head is fetched ahead of time, with a
    // bypass when the word being written becomes the head in the same clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_wr_next == w_rd_next) begin
            r_dout <= '0;
        end else if (w_do_push && (r_wr_ptr == w_rd_next)) begin
            r_dout <= r_push_data;
        end else begin
            r_dout <= r_mem[w_rd_next[AW-1:0]];
        end
    end

    assign pop_data_out = r_dout;
    assign empty        = w_empty;
    assign full         = w_full;
    assign frame_err    = r_frame_err;
    assign parity_err   = r_parity_err;
    assign overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are driven aligned to the bench's own
// baud_tick generator so stop-sample and push cycles are known exactly.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick = 1'b0;
    logic       rxd;
    logic       parity_en;
    logic       parity_odd;
    logic       pop;
    logic       err_clr;
    logic [7:0] pop_data_out;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] div = 2'd0;
    logic       eb;
    logic       ea;

    uart_rx_core #(
        .DATABUS   (8),
        .DEPTH     (16),
        .OVERSAMPLE(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .pop         (pop),
        .err_clr     (err_clr),
        .pop_data_out(pop_data_out),
        .empty       (empty),
        .full        (full),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // One baud_tick every 4 clks, changed on the falling edge.
    always @(negedge clk) begin
        div       = div + 2'd1;
        baud_tick = (div == 2'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge right after the n-th ticked rising edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                              input logic stop, input logic pop_at_push,
                              output logic e_before, output logic e_after);
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_ticks(16);
        end
        if (par_on) begin
            rxd = par_bit;
            wait_ticks(16);
        end
        rxd = stop;
        wait_ticks(9);
        e_before = empty;
        if (pop_at_push) pop = 1'b1;
        @(negedge clk);
        pop     = 1'b0;
        e_after = empty;
        wait_ticks(7);
        if (stop) wait_ticks(16);
        $display("frame data=%02h parity_on=%0b parity_bit=%0b stop=%0b pop_at_push=%0b",
                 d, par_on, par_bit, stop, pop_at_push);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_nonempty"}, empty, 1'b0);
        check(tag, pop_data_out, exp);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        $display("pop expected=%02h", exp);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
        pop = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_flags", {frame_err, parity_err, overrun_err}, 3'b000);
        check("rst_dout", pop_data_out, 8'h00);
        rst = 1'b0;
        wait_ticks(2);

        // 8N1 0xA5: empty falls exactly one clk after the stop sample.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        check("a5_empty_at_stop", eb, 1'b1);
        check("a5_empty_after", ea, 1'b0);
        check("a5_flags", {frame_err, parity_err, overrun_err}, 3'b000);
        pop_expect("a5_data", 8'hA5);
        check("a5_drained", empty, 1'b1);

        // Start-bit glitch of 4 ticks.
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(4);
        rxd = 1'b1;
        wait_ticks(32);
        check("glitch_empty", empty, 1'b1);
        check("glitch_flags", {frame_err, parity_err, overrun_err}, 3'b000);
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        pop_expect("after_glitch_data", 8'h42);

        // Bad stop bit followed by a held break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, eb, ea);
        check("ferr_no_push", ea, 1'b1);
        check("ferr_flag", frame_err, 1'b1);
        wait_ticks(48);
        check("break_empty", empty, 1'b1);
        rxd = 1'b1;
        wait_ticks(16);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        check("after_break_push", ea, 1'b0);
        pop_expect("after_break_data", 8'h11);
        pulse_err_clr();
        check("ferr_cleared", {frame_err, parity_err, overrun_err}, 3'b000);

        // Parity: odd 0x01 with parity bit 1 is wrong (expected 0).
        parity_en = 1'b1; parity_odd = 1'b1;
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, eb, ea);
        check("odd_bad_perr", parity_err, 1'b1);
        check("odd_bad_ferr", frame_err, 1'b0);
        pop_expect("odd_bad_data", 8'h01);
        pulse_err_clr();
        check("perr_cleared", parity_err, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, eb, ea);
        check("odd_good_perr", parity_err, 1'b0);
        pop_expect("odd_good_data", 8'h03);
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, eb, ea);
        check("even_bad_perr", parity_err, 1'b1);
        pop_expect("even_bad_data", 8'h07);
        pulse_err_clr();
        parity_en = 1'b0;

        // Fill 16 words, the 17th overruns and is dropped.
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
            if (i == 14) check("fill15_full", full, 1'b0);
            if (i == 15) begin
                check("fill16_full", full, 1'b1);
                check("fill16_ovr", overrun_err, 1'b0);
            end
        end
        check("fill17_full", full, 1'b1);
        check("fill17_ovr", overrun_err, 1'b1);
        for (int i = 0; i < 16; i++) pop_expect("fill_data", 8'(i));
        check("fill_drained", empty, 1'b1);
        check("fill_drained_full", full, 1'b0);
        pulse_err_clr();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        check("pop_empty_empty", empty, 1'b1);
        check("pop_empty_flags", {frame_err, parity_err, overrun_err}, 3'b000);
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        pop_expect("pop_empty_next", 8'h66);
        check("pop_empty_next_drained", empty, 1'b1);

        // Full FIFO: pop coincides with the push of 0x55.
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        check("full2_full", full, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, eb, ea);
        check("pushpop_full", full, 1'b1);
        check("pushpop_ovr", overrun_err, 1'b0);
        for (int i = 1; i < 16; i++) pop_expect("pushpop_data", 8'h20 + 8'(i));
        pop_expect("pushpop_last", 8'h55);
        check("pushpop_drained", empty, 1'b1);

        // Reset in the middle of a frame with stored data and a flag set.
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        parity_en = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, eb, ea);
        parity_en = 1'b0;
        check("prerst_perr", parity_err, 1'b1);
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(16);
        rxd = 1'b1;
        wait_ticks(16);
        rxd = 1'b0;
        wait_ticks(8);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_empty", empty, 1'b1);
        check("midrst_full", full, 1'b0);
        check("midrst_flags", {frame_err, parity_err, overrun_err}, 3'b000);
        check("midrst_dout", pop_data_out, 8'h00);
        rst = 1'b0;
        rxd = 1'b1;
        wait_ticks(200);
        check("postrst_empty", empty, 1'b1);
        check("postrst_flags", {frame_err, parity_err, overrun_err}, 3'b000);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, eb, ea);
        pop_expect("postrst_data", 8'h5A);
        check("postrst_drained", empty, 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
